// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
// Vector bit positions describe the 4-input selectable-match unit downstream.
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_INPUTS_DEF = 4;
    localparam int N_VEC        = 2**N_INPUTS_DEF;

    localparam int A_BIT    = 3;
    localparam int B_BIT    = 2;
    localparam int SELA_BIT = 1;
    localparam int SELB_BIT = 0;

endpackage

// File: rtl/truth_table_sequencer_settle_counter.sv
// Settle-time counter: cleared on load, counts up while enabled.
// tc flags the last settle cycle of the current vector.
module truth_table_sequencer_settle_counter #(
    parameter int MAX_COUNT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = 4;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(MAX_COUNT - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives every input vector onto the match unit, waits the settle time,
// samples s_in and holds the captured truth table plus its ones count.
//
//   state  | meaning
//   IDLE   | waiting for start; last result held on table_out/ones_count
//   SETTLE | vec driven, waiting SETTLE_CYCLES for the unit to settle
//   SAMPLE | vec still driven, s_in captured into table_out[index]
//   DONE   | one-cycle done pulse, vec released
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_INPUTS      = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [N_INPUTS-1:0]     vec,
    output logic                    vec_valid,
    input  logic                    s_in,
    output logic [2**N_INPUTS-1:0]  table_out,
    output logic [N_INPUTS:0]       ones_count
);

    localparam int NV = 2**N_INPUTS;

    state_t              state;
    logic [N_INPUTS-1:0] index;
    logic                last_vec;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_tc;

    assign last_vec = (index == N_INPUTS'(NV - 1));
    assign cnt_load = ((state == IDLE) && start) || ((state == SAMPLE) && !last_vec);
    assign cnt_en   = (state == SETTLE);

    truth_table_sequencer_settle_counter #(
        .MAX_COUNT (SETTLE_CYCLES)
    ) u_settle_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec        <= '0;
            vec_valid  <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        index      <= '0;
                        table_out  <= '0;
                        ones_count <= '0;
                        vec        <= '0;
                        vec_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_tc) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_out[index] <= s_in;
                    ones_count       <= ones_count + (N_INPUTS + 1)'(s_in);
                    // Terminal test precedes the increment, so index never wraps.
                    if (last_vec) begin
                        busy      <= 1'b0;
                        vec_valid <= 1'b0;
                        vec       <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        index <= index + 1'b1;
                        vec   <= index + 1'b1;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: runs are queued with their expected
// table, a monitor pops and checks on every done pulse.
module tb_truth_table_sequencer;
    import truth_table_sequencer_pkg::*;

    localparam int NV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, s_in, busy, done, vec_valid;
    logic [3:0]  vec;
    logic [15:0] table_out;
    logic [4:0]  ones_count;

    logic        rst3, start3, s_in3, busy3, done3, vec_valid3;
    logic [3:0]  vec3;
    logic [15:0] table_out3;
    logic [4:0]  ones_count3;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int mode = 0;
    logic [15:0] stim_tab = 16'h0;

    typedef struct {
        logic [15:0] tab;
        int          ones;
        int          t;
    } exp_t;
    exp_t sb_q[$];

    truth_table_sequencer #(.N_INPUTS(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .vec(vec), .vec_valid(vec_valid), .s_in(s_in),
        .table_out(table_out), .ones_count(ones_count)
    );

    truth_table_sequencer #(.N_INPUTS(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3),
        .vec(vec3), .vec_valid(vec_valid3), .s_in(s_in3),
        .table_out(table_out3), .ones_count(ones_count3)
    );

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference match unit: s = (a == sel_a) || (b == sel_b), decoded arithmetically.
    function automatic bit model_bit(input int i);
        int a, b, sa, sb;
        a  = (i / 8) % 2;
        b  = (i / 4) % 2;
        sa = (i / 2) % 2;
        sb = i % 2;
        return (a == sa) || (b == sb);
    endfunction

    function automatic logic [15:0] expect_table(input int m, input logic [15:0] tab);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NV; i++) r[i] = (m == 0) ? model_bit(i) : tab[i];
        return r;
    endfunction

    function automatic int popcnt(input logic [15:0] t);
        int c;
        c = 0;
        for (int i = 0; i < NV; i++) c += int'(t[i]);
        return c;
    endfunction

    always_comb s_in  = (mode == 0) ? model_bit(int'(vec)) : stim_tab[vec];
    always_comb s_in3 = model_bit(int'(vec3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue_run(input int m, input logic [15:0] tab, input bit push);
        exp_t e;
        mode     = m;
        stim_tab = tab;
        start    = 1'b1;
        if (push) begin
            e.tab  = expect_table(m, tab);
            e.ones = popcnt(e.tab);
            e.t    = edge_cnt + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("wait_done_in_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_vec"}, {28'd0, vec}, 32'd0);
        check({tag, "_vec_valid"}, {31'd0, vec_valid}, 32'd0);
        check({tag, "_table_out"}, {16'd0, table_out}, 32'd0);
        check({tag, "_ones_count"}, {27'd0, ones_count}, 32'd0);
    endtask

    // Monitor: scoreboard pop on done, and vector ordering while vec_valid.
    logic [3:0] prev_vec = '0;
    logic       prev_vv  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_table_out", {16'd0, table_out}, {16'd0, e.tab});
                    check("sb_ones_count", {27'd0, ones_count}, e.ones);
                    check("sb_done_latency", edge_cnt + 1 - e.t, 1 + NV * 2);
                end
            end
            if (vec_valid === 1'b1 && !prev_vv)
                check("vec_first_zero", {28'd0, vec}, 32'd0);
            else if (vec_valid === 1'b1 && vec != prev_vec)
                check("vec_step_by_one", {28'd0, vec}, {28'd0, prev_vec + 4'd1});
            prev_vec <= vec;
            prev_vv  <= vec_valid;
        end else begin
            prev_vv <= 1'b0;
        end
    end

    task automatic main_seq();
        logic [15:0] r;
        // Golden unit run, result held in IDLE.
        @(negedge clk);
        issue_run(0, 16'h0, 1'b1);
        wait_done();
        @(negedge clk);
        check("golden_table_const", {16'd0, table_out}, 32'h0000EDB7);
        check("golden_ones_const", {27'd0, ones_count}, 32'd12);
        repeat (5) @(negedge clk);
        check("golden_held_in_idle", {16'd0, table_out}, 32'h0000EDB7);

        // All-zero then all-one unit outputs.
        issue_run(1, 16'h0000, 1'b1);
        wait_done();
        repeat (6) @(negedge clk);
        check("zero_held_table", {16'd0, table_out}, 32'h0);
        check("zero_held_ones", {27'd0, ones_count}, 32'd0);
        issue_run(1, 16'hFFFF, 1'b1);
        wait_done();
        repeat (6) @(negedge clk);
        check("ones_held_table", {16'd0, table_out}, 32'h0000FFFF);
        check("ones_held_ones", {27'd0, ones_count}, 32'd16);

        // A new start clears the held result.
        issue_run(0, 16'h0, 1'b1);
        check("start_clears_table", {16'd0, table_out}, 32'h0);
        check("start_clears_ones", {27'd0, ones_count}, 32'd0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done();
        @(negedge clk);

        // start re-pulsed at t+5 and t+20 is ignored.
        issue_run(0, 16'h0, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Reset sampled at t+10 aborts the run without a done pulse.
        issue_run(0, 16'h0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        repeat (40) @(negedge clk);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        issue_run(0, 16'h0, 1'b1);
        wait_done();

        // start in the DONE cycle is ignored; one cycle later it is accepted.
        start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        issue_run(1, 16'hA5C3, 1'b1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done();
        @(negedge clk);

        // Random unit behaviour.
        for (int n = 0; n < 6; n++) begin
            r = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue_run(1, r, 1'b1);
            wait_done();
            @(negedge clk);
        end
    endtask

    task automatic dut3_seq();
        int t3, k, len;
        logic [3:0] cur;
        bit seen_vv, gap;
        seen_vv = 1'b0;
        gap = 1'b0;
        len = 0;
        cur = '0;
        @(negedge clk);
        start3 = 1'b1;
        t3 = edge_cnt + 1;
        @(negedge clk);
        start3 = 1'b0;
        k = 0;
        while (done3 !== 1'b1 && k < 300) begin
            if (busy3 === 1'b1 && vec_valid3 !== 1'b1) gap = 1'b1;
            if (vec_valid3 === 1'b1) begin
                if (!seen_vv) begin
                    check("s3_first_vec", {28'd0, vec3}, 32'd0);
                    seen_vv = 1'b1;
                    cur = vec3;
                    len = 1;
                end else if (vec3 == cur) begin
                    len++;
                end else begin
                    check("s3_vec_hold_cycles", len, 4);
                    check("s3_vec_step", {28'd0, vec3}, {28'd0, cur + 4'd1});
                    cur = vec3;
                    len = 1;
                end
            end
            @(negedge clk);
            k++;
        end
        check("s3_done_seen", {31'd0, done3}, 32'd1);
        check("s3_last_vec_hold_cycles", len, 4);
        check("s3_last_vec", {28'd0, cur}, 32'd15);
        check("s3_vec_valid_continuous", {31'd0, gap}, 32'd0);
        check("s3_done_latency", edge_cnt + 1 - t3, 65);
        check("s3_table_out", {16'd0, table_out3}, {16'd0, expect_table(0, 16'h0)});
        check("s3_ones_count", {27'd0, ones_count3}, 32'd12);
        @(negedge clk);
        check("s3_done_one_cycle", {31'd0, done3}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        rst3   = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset3_busy", {31'd0, busy3}, 32'd0);
        check("reset3_table", {16'd0, table_out3}, 32'd0);
        rst  = 1'b0;
        rst3 = 1'b0;
        fork
            main_seq();
            dut3_seq();
        join
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Sequential stimulus and capture stage placed directly upstream of the 4-input selectable-match logic unit, which computes s = (a XNOR sel_a) OR (b XNOR sel_b).
- On a start request it drives every input combination onto the unit, in index order, and waits a programmable settle time for each one.
- It then samples the unit's output bit and assembles the complete truth table as a packed word, together with a count of the ones.
- The captured table is held for the checker or display logic that follows.

Parameters:
- N_INPUTS, 4, number of driven inputs; the design uses 2**N_INPUTS vectors.
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range is 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high. One clock, no other clock domains.
- start  input  1  one-cycle run request.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when the table is complete.
- vec  output  N_INPUTS  current input vector; bit3=a, bit2=b, bit1=sel_a, bit0=sel_b for N_INPUTS=4.
- vec_valid  output  1  high while vec is being driven (states SETTLE and SAMPLE).
- s_in  input  1  output bit of the downstream logic unit.
- table_out  output  2**N_INPUTS  captured truth table; bit i holds s_in for vec==i.
- ones_count  output  N_INPUTS+1  number of ones in table_out.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, index is 0, settle counter is 0.
- Reset takes priority over every other input in every state. Reset in the middle of a run aborts it, clears table_out and ones_count, and produces no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: index=0, table_out=0, ones_count=0, settle counter=0, go to SETTLE.
- IDLE, start=0: stay in IDLE; table_out and ones_count keep the previous run's result.
- SETTLE: vec=index, vec_valid=1, busy=1. The counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE: vec and vec_valid are held. table_out[index] is loaded with s_in, and ones_count increments by s_in.
  - If index==2**N_INPUTS-1, go to DONE.
  - Otherwise index increments, the counter clears, and the state returns to SETTLE.
- DONE: done=1 for exactly one cycle; busy=0, vec_valid=0, vec=0; go to IDLE.
- start is ignored in SETTLE, SAMPLE and DONE. It is not queued; a new run needs start asserted in IDLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. With start sampled at edge t, done is high in cycle t+1+2**N_INPUTS*(SETTLE_CYCLES+1). For the defaults this is t+33.
- Widths and wrap:
  - index is N_INPUTS bits and never wraps, because the terminal test happens before the increment.
  - ones_count is N_INPUTS+1 bits and holds the maximum value 2**N_INPUTS without overflow.
- s_in is sampled only in SAMPLE; its value in any other state has no effect.

Decomposition:
- Shared package: state enum (IDLE, SETTLE, SAMPLE, DONE), N_VEC = 2**N_INPUTS, and the vector bit-position constants A_BIT, B_BIT, SELA_BIT, SELB_BIT.
- One sub-module, settle_counter: load, enable and terminal flag for the SETTLE_CYCLES count.
- The FSM, index register and capture logic stay in the top module.

Test Plan:
- Golden model: s_in driven combinationally as (vec[3]~^vec[1])|(vec[2]~^vec[0]), start pulsed -> done at t+33, table_out=16'hEDB7 (zero bits at indices 3, 6, 9, 12), ones_count=12.
- s_in tied to 0, then in a second run tied to 1 -> table_out=16'h0000 with ones_count=0, then table_out=16'hFFFF with ones_count=16. The first result stays held in IDLE until the second start.
- SETTLE_CYCLES=3 -> each vec value is stable for exactly 4 cycles, vec_valid is continuous over the run, and done is at t+65.
- start re-pulsed at cycles t+5 and t+20 during a run -> no restart; index continues monotonically and exactly one done pulse occurs.
- rst asserted at t+10 for 1 cycle -> all outputs 0 on the next cycle, no done pulse. A later start produces a full correct run (16'hEDB7).
- start asserted in the DONE cycle -> ignored. start asserted one cycle later -> accepted, and busy rises on the following edge.
